// File: rtl/lowx_mem_arbiter.sv
// lowx_mem_arbiter
//   Shares one lower-level memory port between the instruction side
//   (align buffer / icache refill) and the data side (dcache refill /
//   writeback). Round-robin grant, a single outstanding transaction, and
//   ownership held until the response returns.
//
//   Optional feature macro: LOWX_ARB_TIMEOUT_EN
//     Defined   : watchdog counter over REQ/WAIT; on expiry err_o pulses
//                 together with a zero-data response to the owner, and a
//                 late downstream response is swallowed in DRAIN.
//     Undefined : no counter, no DRAIN, err_o tied 0, unbounded wait.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   i_req_*  / i_flush_i           I-side request and flush
//   i_res_valid_o / i_res_blk_o    I-side response
//   d_req_*                        D-side request (rw = 1 is a write)
//   d_res_valid_o / d_res_blk_o    D-side response
//   mem_req_* / mem_req_ready_i    downstream request (fields latched)
//   mem_res_valid_i / mem_res_blk_i downstream response
//   err_o                          watchdog timeout strobe
module lowx_mem_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BLK_SIZE       = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_req_valid_i,
  input  logic [XLEN-1:0]     i_req_addr_i,
  input  logic                i_req_uncached_i,
  input  logic                i_flush_i,
  output logic                i_res_valid_o,
  output logic [BLK_SIZE-1:0] i_res_blk_o,
  input  logic                d_req_valid_i,
  input  logic [XLEN-1:0]     d_req_addr_i,
  input  logic                d_req_rw_i,
  input  logic [BLK_SIZE-1:0] d_req_wdata_i,
  input  logic                d_req_uncached_i,
  output logic                d_res_valid_o,
  output logic [BLK_SIZE-1:0] d_res_blk_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic                mem_req_rw_o,
  output logic [BLK_SIZE-1:0] mem_req_wdata_o,
  output logic                mem_req_uncached_o,
  input  logic                mem_res_valid_i,
  input  logic [BLK_SIZE-1:0] mem_res_blk_i,
  output logic                err_o
);

`ifdef LOWX_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
`endif

  state_t              state_q;
  logic                owner_d_q;   // 1 = D side owns the port
  logic                last_d_q;    // 1 = last grant went to D
  logic                flushed_q;
  logic [XLEN-1:0]     addr_q;
  logic                rw_q;
  logic [BLK_SIZE-1:0] wdata_q;
  logic                unc_q;

  logic grant_d;
  logic resp_hit;
  logic tmo_hit;
  logic i_drop;

  // Tie goes to the side that did not win last time.
  assign grant_d  = d_req_valid_i & (~i_req_valid_i | ~last_d_q);
  assign resp_hit = (state_q == WAIT) & mem_res_valid_i;

`ifdef LOWX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_done;

  assign cnt_done = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // A response arriving in the expiry cycle of WAIT still completes normally.
  assign tmo_hit  = cnt_done & ((state_q == REQ) | ((state_q == WAIT) & ~mem_res_valid_i));
`else
  assign tmo_hit  = 1'b0;
`endif

  // A flush landing in the response cycle itself also drops the response.
  assign i_drop = flushed_q | i_flush_i;

  assign mem_req_valid_o    = (state_q == REQ) & ~tmo_hit;
  assign mem_req_addr_o     = addr_q;
  assign mem_req_rw_o       = rw_q;
  assign mem_req_wdata_o    = wdata_q;
  assign mem_req_uncached_o = unc_q;

  assign i_res_valid_o = ~owner_d_q & (resp_hit | tmo_hit) & ~i_drop;
  assign d_res_valid_o =  owner_d_q & (resp_hit | tmo_hit);
  assign i_res_blk_o   = resp_hit ? mem_res_blk_i : '0;
  assign d_res_blk_o   = resp_hit ? mem_res_blk_i : '0;
  assign err_o         = tmo_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      last_d_q  <= 1'b1;
      flushed_q <= 1'b0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      unc_q     <= 1'b0;
`ifdef LOWX_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          flushed_q <= 1'b0;
          if (i_req_valid_i | d_req_valid_i) begin
            owner_d_q <= grant_d;
            last_d_q  <= grant_d;
            addr_q    <= grant_d ? d_req_addr_i : i_req_addr_i;
            rw_q      <= grant_d & d_req_rw_i;
            wdata_q   <= grant_d ? d_req_wdata_i : '0;
            unc_q     <= grant_d ? d_req_uncached_i : i_req_uncached_i;
            state_q   <= REQ;
`ifdef LOWX_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        REQ: begin
          if (i_flush_i & ~owner_d_q) flushed_q <= 1'b1;
`ifdef LOWX_ARB_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          if (tmo_hit)              state_q <= IDLE;
          else if (mem_req_ready_i) state_q <= WAIT;
        end
        WAIT: begin
          if (i_flush_i & ~owner_d_q) flushed_q <= 1'b1;
`ifdef LOWX_ARB_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
          if (resp_hit)     state_q <= IDLE;
          else if (tmo_hit) state_q <= DRAIN;
`else
          if (resp_hit)     state_q <= IDLE;
`endif
        end
`ifdef LOWX_ARB_TIMEOUT_EN
        DRAIN: begin
          if (mem_res_valid_i) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Downstream must not respond before the request has been accepted.
  a_no_early_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_res_valid_i |-> !((state_q == IDLE) || (state_q == REQ)));

  a_timeout_min: assert property (@(posedge clk_i) TIMEOUT_CYCLES >= 2);

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Bench for lowx_mem_arbiter: transaction-level reference model plus
// directed scenarios with literal expectations.
module tb_lowx_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         i_req_valid_i, i_req_uncached_i, i_flush_i;
  logic [31:0]  i_req_addr_i;
  logic         i_res_valid_o;
  logic [127:0] i_res_blk_o;
  logic         d_req_valid_i, d_req_rw_i, d_req_uncached_i;
  logic [31:0]  d_req_addr_i;
  logic [127:0] d_req_wdata_i;
  logic         d_res_valid_o;
  logic [127:0] d_res_blk_o;
  logic         mem_req_valid_o, mem_req_ready_i, mem_req_rw_o, mem_req_uncached_o;
  logic [31:0]  mem_req_addr_o;
  logic [127:0] mem_req_wdata_o;
  logic         mem_res_valid_i;
  logic [127:0] mem_res_blk_i;
  logic         err_o;

  lowx_mem_arbiter #(.XLEN(32), .BLK_SIZE(128), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_n),
    .i_req_valid_i(i_req_valid_i), .i_req_addr_i(i_req_addr_i),
    .i_req_uncached_i(i_req_uncached_i), .i_flush_i(i_flush_i),
    .i_res_valid_o(i_res_valid_o), .i_res_blk_o(i_res_blk_o),
    .d_req_valid_i(d_req_valid_i), .d_req_addr_i(d_req_addr_i),
    .d_req_rw_i(d_req_rw_i), .d_req_wdata_i(d_req_wdata_i),
    .d_req_uncached_i(d_req_uncached_i),
    .d_res_valid_o(d_res_valid_o), .d_res_blk_o(d_res_blk_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_rw_o(mem_req_rw_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_uncached_o(mem_req_uncached_o),
    .mem_res_valid_i(mem_res_valid_i), .mem_res_blk_i(mem_res_blk_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction in flight: granted -> accepted downstream -> answered.
  bit           m_busy, m_acc, m_d, m_last_d, m_flushed;
  logic [31:0]  m_addr;
  logic         m_rw, m_unc;
  logic [127:0] m_wdata;
  bit           m_log[$];

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_d = 0; m_last_d = 1; m_flushed = 0;
      m_addr = '0; m_rw = 0; m_unc = 0; m_wdata = '0;
      m_log.delete();
    end else if (!m_busy) begin
      if (i_req_valid_i || d_req_valid_i) begin
        m_d      = d_req_valid_i && (!i_req_valid_i || !m_last_d);
        m_last_d = m_d;
        m_addr   = m_d ? d_req_addr_i : i_req_addr_i;
        m_rw     = m_d ? d_req_rw_i : 1'b0;
        m_unc    = m_d ? d_req_uncached_i : i_req_uncached_i;
        m_wdata  = d_req_wdata_i;
        m_busy   = 1; m_acc = 0; m_flushed = 0;
        m_log.push_back(m_d);
      end
    end else begin
      if (i_flush_i && !m_d) m_flushed = 1;
      if (!m_acc) begin
        if (mem_req_ready_i) m_acc = 1;
      end else if (mem_res_valid_i) begin
        m_busy = 0; m_flushed = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en && rst_n) begin
      bit exp_v, resp;
      exp_v = m_busy && !m_acc;
      resp  = m_busy && m_acc && mem_res_valid_i;
      chk("mreq_valid", {127'd0, mem_req_valid_o}, {127'd0, exp_v});
      if (exp_v) begin
        chk("mreq_addr", {96'd0, mem_req_addr_o}, {96'd0, m_addr});
        chk("mreq_rw",   {127'd0, mem_req_rw_o}, {127'd0, m_rw});
        chk("mreq_unc",  {127'd0, mem_req_uncached_o}, {127'd0, m_unc});
        if (m_rw) chk("mreq_wdata", mem_req_wdata_o, m_wdata);
      end
      chk("i_res_valid", {127'd0, i_res_valid_o},
          {127'd0, resp && !m_d && !m_flushed && !i_flush_i});
      chk("d_res_valid", {127'd0, d_res_valid_o}, {127'd0, resp && m_d});
      if (resp) begin
        chk("i_res_blk", i_res_blk_o, mem_res_blk_i);
        chk("d_res_blk", d_res_blk_o, mem_res_blk_i);
      end
      chk("err", {127'd0, err_o}, 128'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit           was_d, last_i_res, last_d_res, cap_rw;
  logic [127:0] last_blk, cap_wdata;
  int           req_cyc, res_cyc;
  bit           gl[$];

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    i_req_valid_i = 0; i_req_addr_i = '0; i_req_uncached_i = 0; i_flush_i = 0;
    d_req_valid_i = 0; d_req_addr_i = '0; d_req_rw_i = 0; d_req_wdata_i = '0;
    d_req_uncached_i = 0;
    mem_req_ready_i = 0; mem_res_valid_i = 0; mem_res_blk_i = '0;
    repeat (2) step();
    rst_n = 1;
    step();
  endtask

  // Wait for a downstream request, accept it after rdy_lat cycles, answer
  // res_lat cycles later; owners not kept drop valid after their response.
  task automatic serve(input int rdy_lat, input int res_lat, input logic [127:0] blk,
                       input bit keep_i, input bit keep_d, input bit flush_wait);
    int n = 0;
    while (!mem_req_valid_o && n < 20) begin step(); n++; end
    if (!mem_req_valid_o) begin
      chk("grant_wait_timeout", 128'd0, 128'd1);
      return;
    end
    was_d = mem_req_addr_o[31];
    cap_rw = mem_req_rw_o; cap_wdata = mem_req_wdata_o;
    gl.push_back(was_d);
    req_cyc = cyc;
    repeat (rdy_lat) step();
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    if (flush_wait) begin i_flush_i = 1; step(); i_flush_i = 0; end
    repeat (res_lat) step();
    mem_res_valid_i = 1; mem_res_blk_i = blk;
    #1;
    last_i_res = i_res_valid_o; last_d_res = d_res_valid_o;
    last_blk = was_d ? d_res_blk_o : i_res_blk_o;
    res_cyc = cyc;
    step();
    mem_res_valid_i = 0; mem_res_blk_i = '0;
    if (!was_d && !keep_i) i_req_valid_i = 0;
    if (was_d && !keep_d)  d_req_valid_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [127:0] A5 = {16{8'hA5}};
  logic [127:0] WD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  bit exp_ord[6] = '{0, 1, 0, 1, 0, 1};
  int t0;

  initial begin
    // ---- reset state ----
    do_reset();
    chk("rst_mreq_valid", {127'd0, mem_req_valid_o}, 128'd0);
    chk("rst_mreq_addr",  {96'd0, mem_req_addr_o}, 128'd0);
    chk("rst_i_res",      {127'd0, i_res_valid_o}, 128'd0);
    chk("rst_d_res",      {127'd0, d_res_valid_o}, 128'd0);

    // ---- I-only read: ready at cycle 2, response at cycle 5 ----
    i_req_valid_i = 1; i_req_addr_i = 32'h0000_1000; t0 = cyc;
    serve(1, 2, A5, 0, 0, 0);
    chk("t1_req_cycle", req_cyc - t0, 128'd1);
    chk("t1_res_cycle", res_cyc - t0, 128'd5);
    chk("t1_owner",     {127'd0, was_d}, 128'd0);
    chk("t1_i_res",     {127'd0, last_i_res}, 128'd1);
    chk("t1_d_res",     {127'd0, last_d_res}, 128'd0);
    chk("t1_blk",       last_blk, A5);
    step();
    chk("t1_i_res_once", {127'd0, i_res_valid_o}, 128'd0);

    // ---- simultaneous I and D after reset ----
    do_reset();
    i_req_valid_i = 1; i_req_addr_i = 32'h0000_2000;
    d_req_valid_i = 1; d_req_addr_i = 32'h8000_0040; d_req_rw_i = 1; d_req_wdata_i = WD;
    serve(0, 1, 128'h11, 0, 1, 0);
    chk("t2_first_owner", {127'd0, was_d}, 128'd0);
    t0 = res_cyc;
    serve(0, 1, 128'h22, 0, 0, 0);
    chk("t2_second_owner", {127'd0, was_d}, 128'd1);
    chk("t2_d_grant_lat", req_cyc - t0, 128'd2);
    chk("t2_rw",          {127'd0, cap_rw}, 128'd1);
    chk("t2_wdata",       cap_wdata, WD);
    chk("t2_d_res",       {127'd0, last_d_res}, 128'd1);
    chk("t2_blk",         last_blk, 128'h22);
    d_req_rw_i = 0;
    step();

    // ---- both continuously valid: alternating grants ----
    do_reset();
    gl.delete();
    i_req_valid_i = 1; i_req_addr_i = 32'h0000_6000; i_req_uncached_i = 1;
    d_req_valid_i = 1; d_req_addr_i = 32'h8000_0100; d_req_uncached_i = 0;
    for (int k = 0; k < 6; k++) serve(k % 2, k % 3, 128'(k + 1), 1, 1, 0);
    i_req_valid_i = 0; d_req_valid_i = 0; i_req_uncached_i = 0;
    chk("t3_dut_count", gl.size(), 128'd6);
    chk("t3_model_count", m_log.size(), 128'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < gl.size())    chk($sformatf("t3_dut_order%0d", k), {127'd0, gl[k]}, {127'd0, exp_ord[k]});
      if (k < m_log.size()) chk($sformatf("t3_model_order%0d", k), {127'd0, m_log[k]}, {127'd0, exp_ord[k]});
    end
    step(); step();

    // ---- I flush while waiting; D unaffected by flush ----
    do_reset();
    i_req_valid_i = 1; i_req_addr_i = 32'h0000_5000;
    serve(0, 0, A5, 0, 0, 1);
    chk("t4_i_owner",   {127'd0, was_d}, 128'd0);
    chk("t4_i_dropped", {127'd0, last_i_res}, 128'd0);
    d_req_valid_i = 1; d_req_addr_i = 32'h8000_0080; d_req_rw_i = 0;
    serve(1, 1, 128'h33, 0, 0, 1);
    chk("t4_d_owner", {127'd0, was_d}, 128'd1);
    chk("t4_d_res",   {127'd0, last_d_res}, 128'd1);
    chk("t4_d_blk",   last_blk, 128'h33);
    step();

    // ---- asynchronous reset while waiting ----
    i_req_valid_i = 1; i_req_addr_i = 32'h0000_3000; i_req_uncached_i = 1;
    step(); step();
    chk("t5_req_seen", {127'd0, mem_req_valid_o}, 128'd1);
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    #2;
    rst_n = 0; i_req_valid_i = 0; i_req_uncached_i = 0;
    #1;
    chk("t5_mreq_valid", {127'd0, mem_req_valid_o}, 128'd0);
    chk("t5_mreq_addr",  {96'd0, mem_req_addr_o}, 128'd0);
    chk("t5_mreq_unc",   {127'd0, mem_req_uncached_o}, 128'd0);
    chk("t5_mreq_rw",    {127'd0, mem_req_rw_o}, 128'd0);
    chk("t5_mreq_wdata", mem_req_wdata_o, 128'd0);
    chk("t5_i_res",      {127'd0, i_res_valid_o}, 128'd0);
    chk("t5_d_res",      {127'd0, d_res_valid_o}, 128'd0);
    chk("t5_blks",       i_res_blk_o | d_res_blk_o, 128'd0);
    chk("t5_err",        {127'd0, err_o}, 128'd0);
    step(); step();
    rst_n = 1;
    step();
    i_req_valid_i = 1; i_req_addr_i = 32'h0000_4000;
    serve(0, 0, 128'h44, 0, 0, 0);
    chk("t5_regrant_owner", {127'd0, was_d}, 128'd0);
    chk("t5_regrant_res",   {127'd0, last_i_res}, 128'd1);
    step();

`ifdef LOWX_ARB_TIMEOUT_EN
    // ---- watchdog expiry in REQ ----
    do_reset();
    chk_en = 0;
    i_req_valid_i = 1; i_req_addr_i = 32'h0000_7000;
    step();
    for (int k = 1; k <= 15; k++) begin
      chk("t6_req_held", {127'd0, mem_req_valid_o}, 128'd1);
      chk("t6_no_err",   {127'd0, err_o}, 128'd0);
      step();
    end
    chk("t6_err",         {127'd0, err_o}, 128'd1);
    chk("t6_i_res",       {127'd0, i_res_valid_o}, 128'd1);
    chk("t6_i_blk",       i_res_blk_o, 128'd0);
    chk("t6_req_dropped", {127'd0, mem_req_valid_o}, 128'd0);
    step();
    i_req_valid_i = 0;
    #1;
    chk("t6_idle_req", {127'd0, mem_req_valid_o}, 128'd0);
    chk("t6_err_once", {127'd0, err_o}, 128'd0);
    do_reset();
    chk_en = 1;
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lowx_mem_arbiter.md
Name: lowx_mem_arbiter

Overview:
- Shares the single lower-level memory port between the instruction side (align buffer/icache refill) and the data side (dcache refill/writeback).
- Round-robin arbitration; one outstanding transaction; ownership held until the response returns.
- Sits between the fetch/LSU miss paths and the memory interconnect.

Parameters:
- XLEN, 32, address width
- BLK_SIZE, 128, line/data width in bits
- TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only); minimum 2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- i_req_valid_i  in  1  I-side request
- i_req_addr_i  in  XLEN  I-side line address
- i_req_uncached_i  in  1  I-side uncached attribute
- i_flush_i  in  1  I-side flush; drop the pending I response
- i_res_valid_o  out  1  I-side response strobe
- i_res_blk_o  out  BLK_SIZE  I-side response data
- d_req_valid_i  in  1  D-side request
- d_req_addr_i  in  XLEN  D-side address
- d_req_rw_i  in  1  1 = write
- d_req_wdata_i  in  BLK_SIZE  D-side write data
- d_req_uncached_i  in  1  D-side uncached attribute
- d_res_valid_o  out  1  D-side response strobe
- d_res_blk_o  out  BLK_SIZE  D-side response data
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream accept
- mem_req_addr_o  out  XLEN  latched address
- mem_req_rw_o  out  1  latched rw; 0 for I-side
- mem_req_wdata_o  out  BLK_SIZE  latched write data
- mem_req_uncached_o  out  1  latched attribute
- mem_res_valid_i  in  1  downstream response
- mem_res_blk_i  in  BLK_SIZE  downstream data
- err_o  out  1  timeout error strobe (optional feature; tied 0 otherwise)

Behaviour:
- States: IDLE, REQ, WAIT, DRAIN. DRAIN exists only with the optional feature.
- Reset: state IDLE, owner = I, last_grant = D, so I wins the first tie. All outputs 0, and the mem_req_* latches clear to 0.
- IDLE:
  - If any request valid, grant: only one valid goes to that side; both valid goes to the side not equal to last_grant.
  - Latch addr, rw, wdata and uncached; set owner; set last_grant = owner; go to REQ.
  - No combinational path from request inputs to mem_req_*; one cycle grant latency.
- REQ:
  - mem_req_valid_o = 1 with the latched fields, held stable.
  - mem_req_ready_i = 1 goes to WAIT.
- WAIT:
  - mem_req_valid_o = 0.
  - On mem_res_valid_i = 1, the owner's res_valid_o = 1 in the same cycle (combinational), with res_blk_o = mem_res_blk_i; go to IDLE.
  - The non-owner's res_valid_o stays 0. res_blk_o holds mem_res_blk_i on both sides; consumers qualify it with valid.
- Requester contract: hold req_valid and fields until its res_valid. A request still valid in the cycle after the response is a new request.
- Flush:
  - i_flush_i while owner = I in REQ/WAIT sets a flushed flag.
  - The transaction completes downstream normally, but i_res_valid_o is suppressed; the flag clears on return to IDLE.
  - Flush in IDLE, or while owner = D, has no effect.
- Requests arriving while busy wait, with no starvation: after a D transaction, a pending I request wins, and vice versa.
- mem_res_valid_i in IDLE/REQ is ignored (protocol violation; assertion).

Optional Feature:
- Macro: LOWX_ARB_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on entry to REQ and increments in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES in REQ: deassert mem_req_valid_o, pulse err_o and the owner's res_valid_o with blk = 0 (suppressed for I if flushed), go to IDLE.
  - On reaching it in WAIT: same pulses, go to DRAIN.
  - DRAIN: no grants; the next mem_res_valid_i is swallowed, then go to IDLE.
- Disabled: no counter, no DRAIN, err_o tied 0, unbounded wait.

Test Plan:
- I-only read, addr 0x0000_1000, ready at cycle 2, response at cycle 5 with blk 0xA5..A5 -> mem_req_valid_o cycles 1-2, i_res_valid_o one cycle at 5 with matching blk, d_res_valid_o stays 0.
- I and D valid together after reset, D write addr 0x8000_0040 -> I granted first; D granted in the IDLE cycle after I's response, with mem_req_rw_o = 1 and wdata passed through.
- Both continuously valid for 6 transactions -> grant order I,D,I,D,I,D.
- I fetch in WAIT, i_flush_i pulsed, then mem response -> i_res_valid_o stays 0; next D request granted normally.
- Reset asserted in WAIT -> all outputs 0 asynchronously; after release, a new I request is granted cleanly.
- With LOWX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, mem_req_ready_i held 0 -> at cycle 16 of REQ, err_o and i_res_valid_o pulse, blk = 0, return to IDLE.
